clkmon: RTL

Receiving-side checker for testbench clocks: `clkmon` samples a monitored clock as a data input in the bench's reference clock domain. It measures each full period in reference-clock cycles and checks the measurement against a window. It reports lock, stop, and sticky error status. It sits in testbenches next to any clock-generator instance, so tests can prove a generated clock was started, held its frequency, and was stopped cleanly.

---
 rtl/clkmon.sv | 97 +++++++++
 1 files changed

// File: rtl/clkmon.sv
// clkmon: measures a monitored clock's period in reference-clock cycles and reports lock, stop and sticky error status.
module clkmon #(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 14,
    parameter int MAX_PERIOD = 18,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             stopped,
    output logic             err
);
    localparam int G_W = $clog2(LOCK_COUNT + 1);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, STOPPED} state_t;
    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic [G_W-1:0]   good_q, good_d;
    logic             vld_q, locked_q, stopped_q, err_q, err_d;
    logic             rise, in_range, report, err_set;
    always_comb begin
        rise     = s2_q & ~s3_q;
        in_range = cnt_q >= CNT_W'(MIN_PERIOD) && cnt_q <= CNT_W'(MAX_PERIOD);
        // only an edge with a known predecessor yields a meaningful period
        report   = rise && (state_q == ACQ || state_q == LOCKED);
        cnt_d    = rise ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
        period_d = report ? cnt_q : period_q;
        state_d  = state_q;
        good_d   = good_q;
        err_set  = 1'b0;
        case (state_q)
            IDLE, STOPPED: begin
                if (rise) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end
            ACQ: begin
                if (rise) begin
                    good_d  = in_range ? good_q + 1'b1 : '0;
                    state_d = (in_range && good_q + 1'b1 == G_W'(LOCK_COUNT)) ? LOCKED : ACQ;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = STOPPED;
                end
            end
            LOCKED: begin
                if (rise && !in_range) begin
                    err_set = 1'b1;
                    state_d = ACQ;
                    good_d  = '0;
                end else if (!rise && cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = STOPPED;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_set | (err_q & ~clr_err);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            cnt_q     <= '0;
            good_q    <= '0;
            period_q  <= '0;
            vld_q     <= 1'b0;
            locked_q  <= 1'b0;
            stopped_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= clk_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            period_q  <= period_d;
            vld_q     <= report;
            locked_q  <= state_d == LOCKED;
            stopped_q <= state_d == STOPPED;
            err_q     <= err_d;
        end
    end
    assign period     = period_q;
    assign period_vld = vld_q;
    assign locked     = locked_q;
    assign stopped    = stopped_q;
    assign err        = err_q;
endmodule
